pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Program-counter and fetch-control stage that sits directly upstream of instruction_mem and drives its instruction_addr input every cycle. It holds the PC and selects the next PC from sequential, branch or JALR sources. It also handles stall, halt/resume and a sticky fetch-fault state for misaligned or out-of-range targets. It exposes fetch_valid and a retired-fetch counter for the decode stage and for benches.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
IMEM_DEPTH_WORDS, 64, number of 32-bit words in instruction_mem; valid PCs are RESET_VECTOR .. RESET_VECTOR + 4*IMEM_DEPTH_WORDS - 4.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
stall  input  1  hold the PC this cycle.
pc_src  input  2  next-PC select: 00 = pc+4, 01 = branch_target, 10 = jalr_target, 11 = pc+4 (reserved).
branch_target  input  32  PC-relative target computed by the ALU/branch unit.
jalr_target  input  32  register-based target, raw (bit 0 not yet cleared).
halt_req  input  1  enter HALTED at the next edge.
resume  input  1  leave HALTED at the next edge.
instruction_addr  output  32  current PC, wired to instruction_mem.instruction_addr.
pc_plus4  output  32  instruction_addr + 4, combinational (link value for JAL/JALR).
fetch_valid  output  1  instruction_addr is a live fetch this cycle.
fault  output  1  sticky fetch fault.
fault_addr  output  32  offending target captured at the fault.
state  output  2  00 = RESET, 01 = RUN, 10 = HALTED, 11 = FAULT.
retired_count  output  32  count of PC advances since reset.

Behaviour:
- Reset (rst_n low, asynchronous): pc = RESET_VECTOR, state = RESET, fetch_valid = 0, fault = 0, fault_addr = 0, retired_count = 0. The effect is immediate, not clock-dependent.
- instruction_addr = pc register, driven directly with no combinational path from inputs. Single-cycle design: instruction_mem returns data in the same cycle.
- RESET: the first rising edge after rst_n deasserts moves to RUN; pc is unchanged, so the first fetch is at RESET_VECTOR. fetch_valid = 0 in RESET.
- RUN: fetch_valid = 1. Candidate next PC:
  - pc_src 00 or 11: pc + 4.
  - 01: branch_target.
  - 10: {jalr_target[31:1], 1'b0}.
- Fault check on the candidate: fault if candidate[1:0] != 0, or candidate < RESET_VECTOR, or candidate > RESET_VECTOR + 4*IMEM_DEPTH_WORDS - 4. Arithmetic is unsigned 32-bit; pc+4 wrap past 2^32 is caught by the range check.
- Per-edge priority in RUN, highest first:
  1. stall = 1: hold pc, no counter change. This suppresses fault check and halt for that cycle.
  2. Fault: state <- FAULT, fault <- 1, fault_addr <- candidate. pc holds the last good value and retired_count is unchanged.
  3. halt_req = 1: state <- HALTED, pc holds, no increment.
  4. Otherwise: pc <- candidate, retired_count <- retired_count + 1 (wraps mod 2^32).
- HALTED: fetch_valid = 0, pc holds, stall/pc_src ignored. resume = 1 at an edge returns to RUN with pc unchanged. halt_req and resume both high: resume wins.
- FAULT: fetch_valid = 0, everything frozen. Sticky until rst_n is asserted; resume and halt_req are ignored.
- pc_plus4 is always instruction_addr + 4, including in HALTED and FAULT.
- Reset asserted mid-operation, in any state, returns all outputs to reset values immediately. Deassertion must be synchronised externally; the block assumes a clean release.

Test Plan:
- Reset/sequential: hold rst_n low 3 cycles, release, pc_src = 00 -> instruction_addr 0x0 (fetch_valid 0), then 0x0 (fetch_valid 1), 0x4, 0x8, 0xC; retired_count = 3 after 0xC appears.
- Branch/JALR: at pc 0x8, pc_src = 01, branch_target = 0x40 -> next pc 0x40. Then pc_src = 10, jalr_target = 0x45 -> next pc 0x44; pc_plus4 = 0x48.
- Faults: pc_src = 01, branch_target = 0x42 -> state 11, fault = 1, fault_addr = 0x42, pc stays at its prior value. Separately, after reset, sequential run to pc 0xFC (IMEM_DEPTH_WORDS = 64), then pc_src = 00 -> fault_addr = 0x100. resume has no effect in either case.
- Stall priority: at pc 0x10, stall = 1 with pc_src = 01, branch_target = 0x3 for 4 cycles -> pc holds 0x10, no fault, count frozen. Drop stall with pc_src = 00 -> 0x14.
- Halt/resume: halt_req at pc 0x20 -> state 10, fetch_valid 0, pc 0x20 held for 5 cycles. resume -> RUN at 0x20, next edge 0x24. halt_req and resume together while HALTED -> RUN.
- Reset mid-run: in FAULT with pc 0x30, pull rst_n low between clock edges -> instruction_addr = 0x0, fault = 0, fault_addr = 0, retired_count = 0, state = 00 before the next edge.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//
// Program-counter and fetch-control stage. It holds the PC, which drives instruction_mem
// directly, and picks the next PC from pc+4, a branch target or a JALR target. It also
// handles stall, halt/resume and a sticky fault for misaligned or out-of-range targets.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   stall             hold the PC this cycle (RUN only)
//   pc_src            00/11 = pc+4, 01 = branch_target, 10 = jalr_target with bit 0 cleared
//   branch_target     PC-relative target from the branch unit
//   jalr_target       raw register-based target
//   halt_req, resume  enter / leave HALTED at the next edge (resume wins when both are set)
//   instruction_addr  current PC (registered, no combinational input path)
//   pc_plus4          instruction_addr + 4
//   fetch_valid       instruction_addr is a live fetch (RUN only)
//   fault, fault_addr sticky fetch fault and the offending target
//   state             00 RESET, 01 RUN, 10 HALTED, 11 FAULT
//   retired_count     number of PC advances since reset
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR     = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_target,
    input  logic [31:0] jalr_target,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] instruction_addr,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [1:0]  state,
    output logic [31:0] retired_count
);

    typedef enum logic [1:0] {
        StReset  = 2'b00,
        StRun    = 2'b01,
        StHalted = 2'b10,
        StFault  = 2'b11
    } state_e;

    // Byte offset of the last valid word relative to RESET_VECTOR.
    localparam logic [31:0] LastOffset = (IMEM_DEPTH_WORDS << 2) - 32'd4;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic [31:0] retired_q, retired_d;

    logic [31:0] pc_inc;
    logic [31:0] candidate;
    logic [31:0] cand_offset;
    logic        cand_fault;

    assign pc_inc = pc_q + 32'd4;

    always_comb begin
        candidate = pc_inc;
        case (pc_src)
            2'b01:   candidate = branch_target;
            2'b10:   candidate = {jalr_target[31:1], 1'b0};
            default: candidate = pc_inc;
        endcase
    end

    // Offset from the base wraps to a huge value when the target lies below RESET_VECTOR,
    // so one unsigned compare covers both ends of the range (and pc+4 wrap-around).
    // RESET_VECTOR is word-aligned, so the offset's low bits give the alignment check.
    assign cand_offset = candidate - RESET_VECTOR;
    assign cand_fault  = (cand_offset[1:0] != 2'b00) || (cand_offset > LastOffset);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StReset;
            pc_q         <= RESET_VECTOR;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'd0;
            retired_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            retired_q    <= retired_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        retired_d    = retired_q;
        case (state_q)
            StReset: state_d = StRun;
            StRun: begin
                // Stall masks the fault check and halt for this cycle.
                if (!stall) begin
                    if (cand_fault) begin
                        state_d      = StFault;
                        fault_d      = 1'b1;
                        fault_addr_d = candidate;
                    end else if (halt_req) begin
                        state_d = StHalted;
                    end else begin
                        pc_d      = candidate;
                        retired_d = retired_q + 32'd1;
                    end
                end
            end
            StHalted: begin
                if (resume) begin
                    state_d = StRun;
                end
            end
            default: ; // StFault is frozen until reset
        endcase
    end

    // Outputs
    always_comb begin
        fetch_valid = 1'b0;
        case (state_q)
            StRun:   fetch_valid = 1'b1;
            default: fetch_valid = 1'b0;
        endcase
    end

    assign instruction_addr = pc_q;
    assign pc_plus4         = pc_inc;
    assign fault            = fault_q;
    assign fault_addr       = fault_addr_q;
    assign state            = state_q;
    assign retired_count    = retired_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: inputs change on the falling edge, outputs are
// checked on the following falling edge (after one rising edge has been applied).
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic [31:0] jalr_target;
    logic        halt_req;
    logic        resume;
    logic [31:0] instruction_addr;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        fault;
    logic [31:0] fault_addr;
    logic [1:0]  state;
    logic [31:0] retired_count;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    pc_fetch_unit #(
        .RESET_VECTOR     (32'h0000_0000),
        .IMEM_DEPTH_WORDS (64)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .pc_src           (pc_src),
        .branch_target    (branch_target),
        .jalr_target      (jalr_target),
        .halt_req         (halt_req),
        .resume           (resume),
        .instruction_addr (instruction_addr),
        .pc_plus4         (pc_plus4),
        .fetch_valid      (fetch_valid),
        .fault            (fault),
        .fault_addr       (fault_addr),
        .state            (state),
        .retired_count    (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Core observable state in one call: pc, state, fetch_valid, retired_count.
    task automatic check_core(input string tag, input logic [31:0] pc, input logic [1:0] st,
                              input logic fv, input logic [31:0] cnt);
        check_eq({tag, ".pc"}, instruction_addr, pc);
        check_eq({tag, ".state"}, {30'd0, state}, {30'd0, st});
        check_eq({tag, ".fv"}, {31'd0, fetch_valid}, {31'd0, fv});
        check_eq({tag, ".cnt"}, retired_count, cnt);
    endtask

    task automatic clear_inputs();
        stall = 1'b0; pc_src = 2'b00; branch_target = 32'd0; jalr_target = 32'd0;
        halt_req = 1'b0; resume = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;

        // ---------------- Phase A: reset, sequential, stall, halt, fault, async reset
        repeat (3) tick();
        check_core("rst_hold", 32'h0, 2'b00, 1'b0, 32'd0);
        check_eq("rst_hold.fault", {31'd0, fault}, 32'd0);
        check_eq("rst_hold.faddr", fault_addr, 32'd0);
        rst_n = 1'b1;
        #1;
        check_core("rst_release", 32'h0, 2'b00, 1'b0, 32'd0);
        tick();
        check_core("first_run", 32'h0, 2'b01, 1'b1, 32'd0);
        check_eq("first_run.plus4", pc_plus4, 32'h4);
        tick(); check_core("seq4", 32'h4, 2'b01, 1'b1, 32'd1);
        tick(); check_core("seq8", 32'h8, 2'b01, 1'b1, 32'd2);
        tick(); check_core("seqC", 32'hC, 2'b01, 1'b1, 32'd3);
        check_eq("seqC.plus4", pc_plus4, 32'h10);
        tick(); check_core("seq10", 32'h10, 2'b01, 1'b1, 32'd4);

        // Stall outranks a misaligned branch target.
        stall = 1'b1; pc_src = 2'b01; branch_target = 32'h3;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_core("stall", 32'h10, 2'b01, 1'b1, 32'd4);
            check_eq("stall.fault", {31'd0, fault}, 32'd0);
        end
        stall = 1'b0; pc_src = 2'b00; branch_target = 32'd0;
        tick(); check_core("unstall", 32'h14, 2'b01, 1'b1, 32'd5);
        repeat (3) tick();
        check_core("seq20", 32'h20, 2'b01, 1'b1, 32'd8);

        // Halt: target ignored, pc held.
        halt_req = 1'b1; pc_src = 2'b01; branch_target = 32'h80;
        tick(); check_core("halt", 32'h20, 2'b10, 1'b0, 32'd8);
        halt_req = 1'b0; pc_src = 2'b00; branch_target = 32'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_core("halted", 32'h20, 2'b10, 1'b0, 32'd8);
        end
        check_eq("halted.plus4", pc_plus4, 32'h24);
        resume = 1'b1;
        tick(); check_core("resume", 32'h20, 2'b01, 1'b1, 32'd8);
        resume = 1'b0;
        tick(); check_core("after_resume", 32'h24, 2'b01, 1'b1, 32'd9);
        halt_req = 1'b1;
        tick(); check_core("halt2", 32'h24, 2'b10, 1'b0, 32'd9);
        resume = 1'b1;
        tick(); check_core("both_resume_wins", 32'h24, 2'b01, 1'b1, 32'd9);
        halt_req = 1'b0; resume = 1'b0;
        repeat (3) tick();
        check_core("seq30", 32'h30, 2'b01, 1'b1, 32'd12);

        // Misaligned branch -> sticky fault.
        pc_src = 2'b01; branch_target = 32'h42;
        tick(); check_core("fault_br", 32'h30, 2'b11, 1'b0, 32'd12);
        check_eq("fault_br.fault", {31'd0, fault}, 32'd1);
        check_eq("fault_br.faddr", fault_addr, 32'h42);
        pc_src = 2'b00; branch_target = 32'd0; resume = 1'b1; halt_req = 1'b1;
        repeat (2) tick();
        check_core("fault_sticky", 32'h30, 2'b11, 1'b0, 32'd12);
        check_eq("fault_sticky.faddr", fault_addr, 32'h42);
        check_eq("fault_sticky.plus4", pc_plus4, 32'h34);
        resume = 1'b0; halt_req = 1'b0;

        // Asynchronous reset between edges.
        #2 rst_n = 1'b0;
        #1;
        check_core("async_rst", 32'h0, 2'b00, 1'b0, 32'd0);
        check_eq("async_rst.fault", {31'd0, fault}, 32'd0);
        check_eq("async_rst.faddr", fault_addr, 32'd0);

        // ---------------- Phase B: branch and JALR targets
        tick(); rst_n = 1'b1;
        tick(); check_core("b_run", 32'h0, 2'b01, 1'b1, 32'd0);
        repeat (2) tick();
        check_core("b_seq8", 32'h8, 2'b01, 1'b1, 32'd2);
        pc_src = 2'b01; branch_target = 32'h40;
        tick(); check_core("branch", 32'h40, 2'b01, 1'b1, 32'd3);
        pc_src = 2'b10; jalr_target = 32'h45;
        tick(); check_core("jalr", 32'h44, 2'b01, 1'b1, 32'd4);
        check_eq("jalr.plus4", pc_plus4, 32'h48);
        // pc_src 11 behaves as pc+4.
        pc_src = 2'b11;
        tick(); check_core("src11", 32'h48, 2'b01, 1'b1, 32'd5);
        // JALR target still misaligned after clearing bit 0.
        pc_src = 2'b10; jalr_target = 32'h4F;
        tick(); check_core("jalr_fault", 32'h48, 2'b11, 1'b0, 32'd5);
        check_eq("jalr_fault.faddr", fault_addr, 32'h4E);

        // ---------------- Phase C: sequential run off the end of memory
        clear_inputs();
        rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        tick(); check_core("c_run", 32'h0, 2'b01, 1'b1, 32'd0);
        for (int i = 0; i < 63; i++) tick();
        check_core("last_word", 32'hFC, 2'b01, 1'b1, 32'd63);
        tick(); check_core("range_fault", 32'hFC, 2'b11, 1'b0, 32'd63);
        check_eq("range_fault.faddr", fault_addr, 32'h100);
        check_eq("range_fault.fault", {31'd0, fault}, 32'd1);
        check_eq("range_fault.plus4", pc_plus4, 32'h100);
        resume = 1'b1;
        repeat (2) tick();
        check_core("range_sticky", 32'hFC, 2'b11, 1'b0, 32'd63);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
